// File: rtl/conv_pkg.sv
// Shared widths, configuration address map and reset kernel for the 3x3 convolution filter.
package conv_pkg;
  localparam int PIX_W      = 8;
  localparam int WIN_W      = 72;
  localparam int COEF_W     = 8;
  localparam int PROD_W     = 17;
  localparam int ACC_W      = 21;
  localparam int SHIFT_ADDR = 9;
  localparam int NUM_TAPS   = 9;

  typedef logic signed [COEF_W-1:0] coef_t;

  localparam coef_t RESET_KERNEL [NUM_TAPS] = '{
    8'sd1, 8'sd2, 8'sd1,
    8'sd2, 8'sd4, 8'sd2,
    8'sd1, 8'sd2, 8'sd1
  };

  function automatic logic [PIX_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
    if (v < 0)
      return '0;
    else if (v > 255)
      return '1;
    else
      return v[PIX_W-1:0];
  endfunction
endpackage

// File: rtl/conv3_row.sv
// One window row: registers three signed-by-unsigned products, then their sum.
module conv3_row
  import conv_pkg::*;
(
  input  logic                    clk,
  input  logic [3*PIX_W-1:0]      pix_row,
  input  coef_t                   coef0,
  input  coef_t                   coef1,
  input  coef_t                   coef2,
  output logic signed [ACC_W-1:0] row_sum
);
  coef_t                    coef [3];
  logic signed [PROD_W-1:0] prod_d [3];
  logic signed [PROD_W-1:0] prod_q [3];
  logic signed [ACC_W-1:0]  row_sum_d;
  logic signed [ACC_W-1:0]  row_sum_q;

  always_comb begin
    coef[0] = coef0;
    coef[1] = coef1;
    coef[2] = coef2;
    for (int unsigned i = 0; i < 3; i++) begin
      // Zero-extend the pixel so it multiplies as a non-negative signed value.
      prod_d[i] = PROD_W'(coef[i]) *
                  PROD_W'($signed({1'b0, pix_row[3*PIX_W-1-PIX_W*i -: PIX_W]}));
    end
    row_sum_d = ACC_W'(prod_q[0]) + ACC_W'(prod_q[1]) + ACC_W'(prod_q[2]);
  end

  always_ff @(posedge clk) begin
    prod_q    <= prod_d;
    row_sum_q <= row_sum_d;
  end

  assign row_sum = row_sum_q;
endmodule

// File: rtl/conv3x3_filter.sv
// 3x3 convolution with programmable signed kernel and output shift, 3-stage pipeline.
module conv3x3_filter
  import conv_pkg::*;
#(
  parameter int unsigned DEFAULT_SHIFT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIN_W-1:0]  in_window,
  input  logic              in_window_valid,
  input  logic              coef_wr_en,
  input  logic [3:0]        coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  output logic [PIX_W-1:0]  out_pixel,
  output logic              out_pixel_valid,
  output logic [15:0]       out_count
);
  coef_t                   coef_d [NUM_TAPS];
  coef_t                   coef_q [NUM_TAPS];
  logic [3:0]              shift_d, shift_q;
  logic [3:0]              shift_s1_d, shift_s1_q;
  logic [3:0]              shift_s2_d, shift_s2_q;
  logic                    valid_s1_d, valid_s1_q;
  logic                    valid_s2_d, valid_s2_q;
  logic                    out_pixel_valid_d, out_pixel_valid_q;
  logic [PIX_W-1:0]        out_pixel_d, out_pixel_q;
  logic [15:0]             out_count_d, out_count_q;
  logic signed [ACC_W-1:0] row_sum [3];
  logic signed [ACC_W-1:0] total_sum;
  logic signed [ACC_W-1:0] shifted_sum;

  for (genvar r = 0; r < 3; r++) begin : g_row
    conv3_row u_row (
      .clk     (clk),
      .pix_row (in_window[WIN_W-1-3*PIX_W*r -: 3*PIX_W]),
      .coef0   (coef_q[3*r]),
      .coef1   (coef_q[3*r+1]),
      .coef2   (coef_q[3*r+2]),
      .row_sum (row_sum[r])
    );
  end

  always_comb begin
    coef_d  = coef_q;
    shift_d = shift_q;
    if (coef_wr_en) begin
      for (int unsigned i = 0; i < NUM_TAPS; i++) begin
        if (coef_addr == 4'(i)) coef_d[i] = coef_data;
      end
      if (coef_addr == 4'(SHIFT_ADDR)) shift_d = coef_data[3:0];
    end
  end

  // The shift in force at S1 capture rides alongside the data to S3.
  always_comb begin
    valid_s1_d        = in_window_valid;
    shift_s1_d        = shift_q;
    valid_s2_d        = valid_s1_q;
    shift_s2_d        = shift_s1_q;
    total_sum         = row_sum[0] + row_sum[1] + row_sum[2];
    shifted_sum       = total_sum >>> shift_s2_q;
    out_pixel_valid_d = valid_s2_q;
    out_pixel_d       = out_pixel_q;
    if (valid_s2_q) out_pixel_d = saturate(shifted_sum);
    out_count_d       = out_count_q + 16'(valid_s2_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      coef_q            <= RESET_KERNEL;
      shift_q           <= 4'(DEFAULT_SHIFT);
      valid_s1_q        <= 1'b0;
      valid_s2_q        <= 1'b0;
      out_pixel_valid_q <= 1'b0;
      out_pixel_q       <= '0;
      out_count_q       <= '0;
    end else begin
      coef_q            <= coef_d;
      shift_q           <= shift_d;
      valid_s1_q        <= valid_s1_d;
      valid_s2_q        <= valid_s2_d;
      out_pixel_valid_q <= out_pixel_valid_d;
      out_pixel_q       <= out_pixel_d;
      out_count_q       <= out_count_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_s1_q <= shift_s1_d;
    shift_s2_q <= shift_s2_d;
  end

  assign out_pixel       = out_pixel_q;
  assign out_pixel_valid = out_pixel_valid_q;
  assign out_count       = out_count_q;
endmodule
